// File: rtl/ssds_scan_controller_if.sv
// Bundle between the SSD bus interface (master) and the scan controller (slave):
// per-digit segment data in, multiplexed pin drive and frame pulse out.
interface ssds_scan_if;
  logic       ctrl_en;
  logic [6:0] ctrl_digit_0;
  logic [6:0] ctrl_digit_1;
  logic [6:0] ctrl_digit_2;
  logic [6:0] ctrl_digit_3;
  logic [3:0] ctrl_dots;
  logic [6:0] seg_out;
  logic       dot_out;
  logic [3:0] digit_sel;
  logic       frame_tick;

  modport master (
    output ctrl_en, ctrl_digit_0, ctrl_digit_1, ctrl_digit_2, ctrl_digit_3, ctrl_dots,
    input  seg_out, dot_out, digit_sel, frame_tick
  );

  modport slave (
    input  ctrl_en, ctrl_digit_0, ctrl_digit_1, ctrl_digit_2, ctrl_digit_3, ctrl_dots,
    output seg_out, dot_out, digit_sel, frame_tick
  );
endinterface

// File: rtl/ssds_scan_controller.sv
// Four-digit seven-segment scan controller: drives one digit per slot, inserts a
// blanking gap between digits and pulses frame_tick at the end of every frame.
module ssds_scan_controller #(
  parameter int DRIVE_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int ACTIVE_LOW   = 1
) (
  input logic         clk,
  input logic         rst,
  ssds_scan_if.slave  bus
);

  localparam int MAX_DB      = (DRIVE_CYCLES > BLANK_CYCLES) ? DRIVE_CYCLES : BLANK_CYCLES;
  localparam int CNT_RANGE   = (MAX_DB > 2) ? MAX_DB : 2;
  localparam int CNT_W       = $clog2(CNT_RANGE);
  localparam int BLANK_LAST_I = (BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0;
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_LAST_I);
  localparam logic INV = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_DRIVE = 2'd1,
    ST_BLANK = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       seg_q, seg_d;
  logic             dot_q, dot_d;
  logic [3:0]       sel_q, sel_d;
  logic             tick_q, tick_d;
  logic             load_s;
  logic [6:0]       pat_s;

  // Next-state logic: ctrl_en low forces OFF from any state.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    load_s  = 1'b0;
    if (!bus.ctrl_en) begin
      state_d = ST_OFF;
      idx_d   = 2'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_DRIVE;
          idx_d   = 2'd0;
          cnt_d   = '0;
          load_s  = 1'b1;
        end
        ST_DRIVE: begin
          if (cnt_q == DRIVE_LAST) begin
            cnt_d = '0;
            if (BLANK_CYCLES == 0) begin
              state_d = ST_DRIVE;
              idx_d   = idx_q + 2'd1;
              load_s  = 1'b1;
            end else begin
              state_d = ST_BLANK;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_DRIVE;
            idx_d   = idx_q + 2'd1;
            cnt_d   = '0;
            load_s  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_OFF;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Pattern of the digit about to be driven.
  always_comb begin
    case (idx_d)
      2'd0:    pat_s = bus.ctrl_digit_0;
      2'd1:    pat_s = bus.ctrl_digit_1;
      2'd2:    pat_s = bus.ctrl_digit_2;
      2'd3:    pat_s = bus.ctrl_digit_3;
      default: pat_s = 7'h00;
    endcase
  end

  // Pin values for the next cycle; data is latched only on DRIVE entry so a slot never tears.
  always_comb begin
    seg_d = {7{INV}};
    dot_d = INV;
    sel_d = {4{INV}};
    if (state_d == ST_DRIVE) begin
      sel_d = (4'b0001 << idx_d) ^ {4{INV}};
      if (load_s) begin
        seg_d = pat_s ^ {7{INV}};
        dot_d = bus.ctrl_dots[idx_d] ^ INV;
      end else begin
        seg_d = seg_q;
        dot_d = dot_q;
      end
    end else begin
      sel_d = {4{INV}};
    end
    if (BLANK_CYCLES == 0) begin
      tick_d = (state_d == ST_DRIVE) && (idx_d == 2'd3) && (cnt_d == DRIVE_LAST);
    end else begin
      tick_d = (state_d == ST_BLANK) && (idx_d == 2'd3) && (cnt_d == BLANK_LAST);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OFF;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      seg_q   <= {7{INV}};
      dot_q   <= INV;
      sel_q   <= {4{INV}};
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
      dot_q   <= dot_d;
      sel_q   <= sel_d;
      tick_q  <= tick_d;
    end
  end

  assign bus.seg_out    = seg_q;
  assign bus.dot_out    = dot_q;
  assign bus.digit_sel  = sel_q;
  assign bus.frame_tick = tick_q;

endmodule
